// File: rtl/multi_debouncer.sv
// Multi-channel input debouncer.
// Each channel passes through its own synchroniser chain. The debounced output
// only follows the synchronised input after it has disagreed with the output
// for STABLE_CYCLES consecutive clocks. One-cycle rise/fall pulses mark each
// output change, and anyChange flags a cycle in which any channel changed.
module multi_debouncer #(
    parameter int   CHANNELS      = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RESET_LEVEL   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                anyChange
);

    // The counter only has to reach STABLE_CYCLES-1, where it is cleared, so
    // clog2 bits are enough. At least one bit is kept for STABLE_CYCLES=1.
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
    logic [CNT_W-1:0]                     r_cnt [CHANNELS];
    logic [CHANNELS-1:0]                  r_out;
    logic [CHANNELS-1:0]                  r_rise;
    logic [CHANNELS-1:0]                  r_fall;
    logic [CHANNELS-1:0]                  w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 samples the raw pins, the last stage feeds the debouncer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= {CHANNELS{RESET_LEVEL}};
            end
        end else begin
            r_sync[0] <= in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Per-channel stability counter, output update and edge pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_cnt[ch] <= '0;
            end
            r_out  <= {CHANNELS{RESET_LEVEL}};
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_rise[ch] <= 1'b0;
                r_fall[ch] <= 1'b0;
                if (w_synced[ch] != r_out[ch]) begin
                    if (r_cnt[ch] == CNT_LAST) begin
                        r_out[ch]  <= w_synced[ch];
                        r_cnt[ch]  <= '0;
                        r_rise[ch] <= w_synced[ch];
                        r_fall[ch] <= ~w_synced[ch];
                    end else begin
                        r_cnt[ch] <= r_cnt[ch] + 1'b1;
                    end
                end else begin
                    // Any agreement restarts the count, so short glitches are dropped.
                    r_cnt[ch] <= '0;
                end
            end
        end
    end

    assign out       = r_out;
    assign rise      = r_rise;
    assign fall      = r_fall;
    assign anyChange = (|r_rise) | (|r_fall);

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: a 2-channel/4-cycle instance and an
// 8-channel/1-cycle instance share one clock and one reset.
module tb_multi_debouncer;

    logic       clk;
    logic       reset;

    logic [1:0] a_in, a_out, a_rise, a_fall;
    logic       a_any;
    logic [7:0] b_in, b_out, b_rise, b_fall;
    logic       b_any;

    int n_cmp;
    int n_err;

    multi_debouncer #(
        .CHANNELS(2), .STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .in(a_in), .out(a_out),
        .rise(a_rise), .fall(a_fall), .anyChange(a_any)
    );

    multi_debouncer #(
        .CHANNELS(8), .STABLE_CYCLES(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .in(b_in), .out(b_out),
        .rise(b_rise), .fall(b_fall), .anyChange(b_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply new_in to instance A and watch edges 1..7: the output must change
    // at edge 6 with the given pulses, and be quiet on every other edge.
    task automatic a_transition(input string tag, input logic [1:0] new_in,
                                input logic [1:0] old_out, input logic [1:0] new_out,
                                input logic [1:0] rpulse, input logic [1:0] fpulse);
        a_in = new_in;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("%s_out_e%0d", tag, k),  a_out,  (k >= 6) ? new_out : old_out);
            check($sformatf("%s_rise_e%0d", tag, k), a_rise, (k == 6) ? rpulse : 2'b00);
            check($sformatf("%s_fall_e%0d", tag, k), a_fall, (k == 6) ? fpulse : 2'b00);
            check($sformatf("%s_any_e%0d", tag, k),  a_any,  (k == 6) ? (|(rpulse | fpulse)) : 1'b0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        a_in  = 2'b11;
        b_in  = 8'hFF;

        // Reset state
        repeat (3) tick();
        check("rst_a_out", a_out, 2'b11);
        check("rst_a_rise", a_rise, 2'b00);
        check("rst_a_fall", a_fall, 2'b00);
        check("rst_a_any", a_any, 1'b0);
        check("rst_b_out", b_out, 8'hFF);
        check("rst_b_pulses", {b_rise, b_fall}, 16'h0000);

        reset = 1'b1;
        repeat (3) tick();
        check("idle_a_out", a_out, 2'b11);

        // Clean edge on channel 0, then back high
        a_transition("clean_fall", 2'b10, 2'b11, 2'b10, 2'b00, 2'b01);
        a_transition("clean_rise", 2'b11, 2'b10, 2'b11, 2'b01, 2'b00);

        // Glitch of three cycles on channel 0 is rejected
        a_in = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("glitch_lo_out_e%0d", k), a_out, 2'b11);
            check($sformatf("glitch_lo_fall_e%0d", k), a_fall, 2'b00);
        end
        a_in = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("glitch_hi_out_e%0d", k), a_out, 2'b11);
            check($sformatf("glitch_hi_fall_e%0d", k), a_fall, 2'b00);
            check($sformatf("glitch_hi_any_e%0d", k), a_any, 1'b0);
        end
        // A following clean edge needs the full latency again (counter was cleared)
        a_transition("post_glitch_fall", 2'b10, 2'b11, 2'b10, 2'b00, 2'b01);
        a_transition("post_glitch_rise", 2'b11, 2'b10, 2'b11, 2'b01, 2'b00);

        // Simultaneous channels
        a_transition("both_fall", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
        a_transition("both_rise", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00);

        // Reset during a pending count
        a_in = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("mid_cnt_out_e%0d", k), a_out, 2'b11);
        end
        reset = 1'b0;
        tick();
        check("mid_rst_out", a_out, 2'b11);
        check("mid_rst_rise", a_rise, 2'b00);
        check("mid_rst_fall", a_fall, 2'b00);
        check("mid_rst_any", a_any, 1'b0);
        reset = 1'b1;
        a_transition("after_rst_fall", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
        a_transition("after_rst_rise", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00);

        // Walking zero on the 8-channel, single-cycle instance
        for (int ch = 0; ch < 8; ch++) begin
            logic [7:0] onehot, prev_pat, new_pat, prev_rise;
            onehot    = 8'h01 << ch;
            new_pat   = ~onehot;
            prev_pat  = (ch == 0) ? 8'hFF : ~(onehot >> 1);
            prev_rise = (ch == 0) ? 8'h00 : (onehot >> 1);
            b_in = new_pat;
            for (int k = 1; k <= 4; k++) begin
                tick();
                check($sformatf("walk%0d_out_e%0d", ch, k), b_out, (k >= 3) ? new_pat : prev_pat);
                check($sformatf("walk%0d_fall_e%0d", ch, k), b_fall, (k == 3) ? onehot : 8'h00);
                check($sformatf("walk%0d_rise_e%0d", ch, k), b_rise, (k == 3) ? prev_rise : 8'h00);
                check($sformatf("walk%0d_any_e%0d", ch, k), b_any, (k == 3) ? 1'b1 : 1'b0);
            end
        end
        b_in = 8'hFF;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("walk_end_out_e%0d", k), b_out, (k >= 3) ? 8'hFF : 8'h7F);
            check($sformatf("walk_end_rise_e%0d", k), b_rise, (k == 3) ? 8'h80 : 8'h00);
            check($sformatf("walk_end_fall_e%0d", k), b_fall, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent input channels, legal range 1 or more.
REQ-002 SHALL have parameter STABLE_CYCLES, default 16: consecutive synchronised mismatch cycles required before an output changes, legal range 1 or more.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser flip-flop depth, legal range 2 or more.
REQ-004 SHALL have parameter RESET_LEVEL, default 1: level loaded into every synchroniser stage and output on reset (PS/2 lines idle high).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port in, input, CHANNELS bits: raw asynchronous inputs, e.g. ps2Clk and ps2Data.
REQ-008 SHALL have port out, output, CHANNELS bits: debounced levels, registered.
REQ-009 SHALL have port rise, output, CHANNELS bits: one-cycle pulse when out[i] goes 0 to 1, registered.
REQ-010 SHALL have port fall, output, CHANNELS bits: one-cycle pulse when out[i] goes 1 to 0, registered.
REQ-011 SHALL have port anyChange, output, 1 bit: OR of all rise and fall bits.

Function
REQ-012 SHALL give each channel its own SYNC_STAGES-deep synchroniser, counter and output register, with no cross-channel coupling.
REQ-013 SHALL size each counter to clog2(STABLE_CYCLES) bits, minimum 1 bit, so it never wraps.
REQ-014 SHALL, when synced[i] differs from out[i] and the count is below STABLE_CYCLES-1, increment the count.
REQ-015 SHALL, when synced[i] differs from out[i] and the count equals STABLE_CYCLES-1, set out[i] to synced[i], clear the count, and assert the matching rise[i] or fall[i] on that same edge.
REQ-016 SHALL, when synced[i] equals out[i], clear the count, so any glitch shorter than STABLE_CYCLES synchronised cycles produces no output change.
REQ-017 SHALL deassert rise[i] and fall[i] on every edge other than the edge on which out[i] changes; the two are never high together.
REQ-018 SHALL change out[i] exactly at the (SYNC_STAGES+STABLE_CYCLES)-th rising edge after a clean input transition that occurs before edge 1.
REQ-019 SHALL, with STABLE_CYCLES=1, change the output one edge after the mismatch appears at the synchroniser output.
REQ-020 SHALL allow a channel to toggle again immediately after an update, with minimum output period STABLE_CYCLES cycles per level.
REQ-021 SHALL update simultaneous changes on several channels in the same cycle, each with its own pulse; anyChange stays high for that one cycle.

Reset
REQ-022 SHALL, while reset is 0 at a rising edge, load all synchroniser stages and out with RESET_LEVEL, clear all counters, and clear rise and fall.
REQ-023 SHALL, on reset during a count, discard the count with no pulse emitted.
REQ-024 SHALL, if in differs from RESET_LEVEL after reset release, treat it as a normal transition: out changes after SYNC_STAGES+STABLE_CYCLES edges, with a pulse.
REQ-025 SHALL ignore reset except at rising clk edges.

Verification
REQ-026 SHALL cover clean edge (CHANNELS=2, STABLE_CYCLES=4, SYNC_STAGES=2): in[0] goes 1 to 0 before edge 1 -> out[0]=0 and fall[0]=1 at edge 6, fall[0]=0 at edge 7, out[1]=1 throughout.
REQ-027 SHALL cover glitch rejection (same parameters): in[0] low for 3 cycles then high -> out[0] stays 1, no fall, counter returns to 0.
REQ-028 SHALL cover simultaneous channels: both inputs rise together from 0 -> rise=2'b11 and anyChange=1 for exactly one cycle, at edge 6.
REQ-029 SHALL cover reset mid-count: reset=0 at edge 4 of a pending transition -> out=2'b11, rise/fall=0, and a fresh full 6-edge latency after release.
REQ-030 SHALL cover STABLE_CYCLES=1 and CHANNELS=8: a walking-zero pattern, one channel per 4 cycles -> each fall pulse 3 edges after its input change, with no missed or extra pulses.
